// File: rtl/step_dda_mc.sv
// Multi-channel DDA step-pulse generator.
// Each channel spreads a commanded number of STEP pulses evenly over one
// fixed control period of SLOTS slots, with a single-entry command buffer
// so consecutive periods run back to back without gaps.
module step_dda_mc #(
  parameter int NCH      = 3,
  parameter int NW       = 7,
  parameter int SLOTS    = 50,
  parameter int HALF_DIV = 200,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr,
  input  logic [CHW-1:0] wr_ch,
  input  logic           wr_dir,
  input  logic [NW-1:0]  wr_mag,
  output logic [NCH-1:0] pulse,
  output logic [NCH-1:0] dir,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] full,
  output logic [NCH-1:0] ovf
);

  // Accumulator holds values below 2*SLOTS; magnitude is at most SLOTS.
  localparam int AW = $clog2(2 * SLOTS);
  localparam int MW = $clog2(SLOTS + 1);
  localparam int PW = $clog2(2 * HALF_DIV);
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  logic          wr_q, wr_d;
  logic          wr_ev;
  logic [MW-1:0] mag_c;

  // Registered copy of the write strobe; preset high so a strobe held
  // through reset release is not mistaken for a fresh command.
  always_comb wr_d = wr;

  // Write-strobe history register.
  always_ff @(posedge clk) begin
    if (!rst_n) wr_q <= 1'b1;
    else        wr_q <= wr_d;
  end

  assign wr_ev = wr & ~wr_q;

  // Clamp the commanded step count to one pulse per slot.
  always_comb mag_c = (int'(wr_mag) > SLOTS) ? MW'(SLOTS) : MW'(wr_mag);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [MW-1:0] mag_q, mag_d;
    logic [MW-1:0] bmag_q, bmag_d;
    logic          bdir_q, bdir_d;
    logic          dir_q, dir_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          fire_q, fire_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          pulse_q, pulse_d;
    logic          ev;
    logic          slot_end, period_end;
    logic          ld_new, ld_buf;
    logic [AW:0]   sum_new, sum_buf, sum_run, sum_ld;

    assign ev         = wr_ev && (wr_ch == CHW'(gi));
    assign slot_end   = (state_q == ST_RUN) && (ph_q == PW'(2 * HALF_DIV - 1));
    assign period_end = slot_end && (slot_q == SW'(SLOTS - 1));

    // First DDA step of a period starts from SLOTS/2 to centre the pulses.
    assign sum_new = (AW + 1)'(SLOTS / 2) + (AW + 1)'(mag_c);
    assign sum_buf = (AW + 1)'(SLOTS / 2) + (AW + 1)'(bmag_q);
    assign sum_run = {1'b0, acc_q} + (AW + 1)'(mag_q);

    // Channel sequencing: load/queue/overwrite decisions, slot timebase
    // and the DDA step evaluated as each slot begins.
    always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mag_d   = mag_q;
      bmag_d  = bmag_q;
      bdir_d  = bdir_q;
      dir_d   = dir_q;
      ph_d    = ph_q;
      slot_d  = slot_q;
      fire_d  = fire_q;
      full_d  = full_q;
      ovf_d   = 1'b0;
      ld_new  = 1'b0;
      ld_buf  = 1'b0;
      sum_ld  = sum_new;

      if (state_q == ST_IDLE) begin
        ld_new = ev;
      end else if (period_end) begin
        // A write landing on the boundary is taken as a fresh command,
        // never as an overwrite.
        if (full_q) begin
          ld_buf = 1'b1;
          if (ev) begin
            bmag_d = mag_c;
            bdir_d = wr_dir;
          end else begin
            full_d = 1'b0;
          end
        end else if (ev) begin
          ld_new = 1'b1;
        end else begin
          state_d = ST_IDLE;
          fire_d  = 1'b0;
          ph_d    = '0;
          slot_d  = '0;
        end
      end else begin
        ph_d = slot_end ? '0 : ph_q + 1'b1;
        if (slot_end) begin
          slot_d = slot_q + 1'b1;
          fire_d = (sum_run >= (AW + 1)'(SLOTS));
          acc_d  = fire_d ? AW'(sum_run - (AW + 1)'(SLOTS)) : AW'(sum_run);
        end
        if (ev) begin
          bmag_d = mag_c;
          bdir_d = wr_dir;
          full_d = 1'b1;
          ovf_d  = full_q;
        end
      end

      if (ld_new || ld_buf) begin
        state_d = ST_RUN;
        mag_d   = ld_buf ? bmag_q : mag_c;
        dir_d   = ld_buf ? bdir_q : wr_dir;
        ph_d    = '0;
        slot_d  = '0;
        sum_ld  = ld_buf ? sum_buf : sum_new;
        fire_d  = (sum_ld >= (AW + 1)'(SLOTS));
        acc_d   = fire_d ? AW'(sum_ld - (AW + 1)'(SLOTS)) : AW'(sum_ld);
      end

      // Firing slots are low for the first half and high for the second,
      // so STEP is always low at slot and period boundaries.
      pulse_d = (state_d == ST_RUN) && fire_d && (ph_d >= PW'(HALF_DIV));
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        acc_q   <= '0;
        mag_q   <= '0;
        bmag_q  <= '0;
        bdir_q  <= 1'b0;
        dir_q   <= 1'b0;
        ph_q    <= '0;
        slot_q  <= '0;
        fire_q  <= 1'b0;
        full_q  <= 1'b0;
        ovf_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
        mag_q   <= mag_d;
        bmag_q  <= bmag_d;
        bdir_q  <= bdir_d;
        dir_q   <= dir_d;
        ph_q    <= ph_d;
        slot_q  <= slot_d;
        fire_q  <= fire_d;
        full_q  <= full_d;
        ovf_q   <= ovf_d;
        pulse_q <= pulse_d;
      end
    end

    assign pulse[gi] = pulse_q;
    assign dir[gi]   = dir_q;
    assign busy[gi]  = (state_q == ST_RUN);
    assign full[gi]  = full_q;
    assign ovf[gi]   = ovf_q;
  end

endmodule

// File: tb/tb_step_dda_mc.sv
// Directed bench for step_dda_mc. HALF_DIV is shortened to 10 so one
// period is 1000 cycles; SLOTS keeps its default of 50.
module tb_step_dda_mc;
  localparam int H = 10;
  localparam int P = 2 * H * 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic [1:0] wr_ch = '0;
  logic       wr_dir = 1'b0;
  logic [6:0] wr_mag = '0;
  logic [2:0] pulse, dir, busy, full, ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc = 0;
  int t_wr = 0;

  int rises[3]      = '{0, 0, 0};
  int bad_w[3]      = '{0, 0, 0};
  int busy_cyc[3]   = '{0, 0, 0};
  int setup_viol[3] = '{0, 0, 0};
  int hi_len[3]     = '{0, 0, 0};
  int last_rise[3]  = '{0, 0, 0};
  int dir_chg[3]    = '{-100000, -100000, -100000};
  logic [2:0] pprev = '0;
  logic [2:0] dprev = '0;

  step_dda_mc #(.NCH(3), .NW(7), .SLOTS(50), .HALF_DIV(H)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wr_ch(wr_ch), .wr_dir(wr_dir),
    .wr_mag(wr_mag), .pulse(pulse), .dir(dir), .busy(busy), .full(full),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  // Pulse/busy/dir observer sampled on the falling edge.
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (pulse[c] === 1'b1 && pprev[c] !== 1'b1) begin
        rises[c]     <= rises[c] + 1;
        hi_len[c]    <= 1;
        last_rise[c] <= ncyc;
        if (ncyc - dir_chg[c] < H) setup_viol[c] <= setup_viol[c] + 1;
      end else if (pulse[c] === 1'b1) begin
        hi_len[c] <= hi_len[c] + 1;
      end
      if (pulse[c] === 1'b0 && pprev[c] === 1'b1 && hi_len[c] != H)
        bad_w[c] <= bad_w[c] + 1;
      if (busy[c] === 1'b1) busy_cyc[c] <= busy_cyc[c] + 1;
      if (dir[c] !== dprev[c]) dir_chg[c] <= ncyc;
    end
    pprev <= pulse;
    dprev <= dir;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (ncyc < target) @(negedge clk);
  endtask

  // Returns at the first falling edge after the write edge (cycle T+1).
  task automatic do_write(input int ch, input bit d, input int m);
    @(negedge clk);
    wr = 1'b1; wr_ch = 2'(ch); wr_dir = d; wr_mag = 7'(m);
    @(posedge clk);
    #1 t_wr = ncyc;
    @(negedge clk);
    wr = 1'b0;
    $display("write ch=%0d dir=%0d mag=%0d at cycle %0d", ch, d, m, t_wr);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr = 1'b1; wr_ch = 2'd0; wr_dir = 1'b1; wr_mag = 7'd25;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_neg(5);
    n_cmp++; if (pulse !== 3'b000) begin n_bad++; $display("FAIL reset_pulse: got %b expected 000", pulse); end
    n_cmp++; if (dir !== 3'b000) begin n_bad++; $display("FAIL reset_dir: got %b expected 000", dir); end
    n_cmp++; if (busy !== 3'b000) begin n_bad++; $display("FAIL reset_busy: got %b expected 000", busy); end
    n_cmp++; if (full !== 3'b000) begin n_bad++; $display("FAIL reset_full: got %b expected 000", full); end
    n_cmp++; if (ovf !== 3'b000) begin n_bad++; $display("FAIL reset_ovf: got %b expected 000", ovf); end
    wait_neg(50);
    n_cmp++; if (busy !== 3'b000) begin n_bad++; $display("FAIL reset_wr_held_no_load: got %b expected 000", busy); end
    wr = 1'b0;
    wait_neg(2);
    $display("reset with wr held done at cycle %0d", ncyc);
  endtask

  task automatic test_basic;
    int r0, b0, w0;
    r0 = rises[0]; b0 = busy_cyc[0]; w0 = bad_w[0];
    do_write(0, 1'b1, 25);
    n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL basic_busy_T1: got %b expected 1", busy[0]); end
    n_cmp++; if (dir[0] !== 1'b1) begin n_bad++; $display("FAIL basic_dir_T1: got %b expected 1", dir[0]); end
    wait_neg(H - 1);
    n_cmp++; if (pulse[0] !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_before_rise: got %b expected 0", pulse[0]); end
    wait_neg(1);
    n_cmp++; if (pulse[0] !== 1'b1) begin n_bad++; $display("FAIL basic_pulse_rise: got %b expected 1", pulse[0]); end
    wait_until(t_wr + P - 1);
    n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL basic_busy_last: got %b expected 1", busy[0]); end
    wait_neg(1);
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL basic_busy_fall: got %b expected 0", busy[0]); end
    wait_neg(2);
    n_cmp++; if (rises[0] - r0 !== 25) begin n_bad++; $display("FAIL basic_count: got %0d expected 25", rises[0] - r0); end
    n_cmp++; if (busy_cyc[0] - b0 !== P) begin n_bad++; $display("FAIL basic_busy_len: got %0d expected %0d", busy_cyc[0] - b0, P); end
    n_cmp++; if (bad_w[0] - w0 !== 0) begin n_bad++; $display("FAIL basic_width: got %0d bad expected 0", bad_w[0] - w0); end
    n_cmp++; if (last_rise[0] - t_wr !== 2 * H * 48 + H) begin n_bad++; $display("FAIL basic_last_rise: got %0d expected %0d", last_rise[0] - t_wr, 2 * H * 48 + H); end
  endtask

  task automatic test_full_clamp;
    int mags[3] = '{50, 90, 0};
    int exps[3] = '{50, 50, 0};
    int r0, b0, w0;
    logic exp_hi;
    for (int k = 0; k < 3; k++) begin
      r0 = rises[0]; b0 = busy_cyc[0]; w0 = bad_w[0];
      do_write(0, 1'b0, mags[k]);
      exp_hi = (exps[k] > 0);
      wait_until(t_wr + 2 * H - 1);
      n_cmp++; if (pulse[0] !== exp_hi) begin n_bad++; $display("FAIL fc_slot0_high mag=%0d: got %b expected %b", mags[k], pulse[0], exp_hi); end
      wait_neg(1);
      n_cmp++; if (pulse[0] !== 1'b0) begin n_bad++; $display("FAIL fc_slot1_low mag=%0d: got %b expected 0", mags[k], pulse[0]); end
      wait_until(t_wr + P);
      n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL fc_busy_fall mag=%0d: got %b expected 0", mags[k], busy[0]); end
      wait_neg(2);
      n_cmp++; if (rises[0] - r0 !== exps[k]) begin n_bad++; $display("FAIL fc_count mag=%0d: got %0d expected %0d", mags[k], rises[0] - r0, exps[k]); end
      n_cmp++; if (busy_cyc[0] - b0 !== P) begin n_bad++; $display("FAIL fc_busy_len mag=%0d: got %0d expected %0d", mags[k], busy_cyc[0] - b0, P); end
      n_cmp++; if (bad_w[0] - w0 !== 0) begin n_bad++; $display("FAIL fc_width mag=%0d: got %0d bad expected 0", mags[k], bad_w[0] - w0); end
    end
  endtask

  task automatic test_queue;
    int r1, s1, t1;
    r1 = rises[1]; s1 = setup_viol[1];
    do_write(1, 1'b0, 10);
    t1 = t_wr;
    n_cmp++; if (busy[1] !== 1'b1) begin n_bad++; $display("FAIL q_busy: got %b expected 1", busy[1]); end
    wait_neg(100);
    do_write(1, 1'b1, 5);
    n_cmp++; if (full[1] !== 1'b1) begin n_bad++; $display("FAIL q_full_set: got %b expected 1", full[1]); end
    n_cmp++; if (ovf[1] !== 1'b0) begin n_bad++; $display("FAIL q_no_ovf: got %b expected 0", ovf[1]); end
    wait_until(t1 + P - 1);
    n_cmp++; if ({full[1], dir[1], busy[1]} !== 3'b101) begin n_bad++; $display("FAIL q_before_boundary full/dir/busy: got %b expected 101", {full[1], dir[1], busy[1]}); end
    wait_neg(1);
    n_cmp++; if ({full[1], dir[1], busy[1], pulse[1]} !== 4'b0110) begin n_bad++; $display("FAIL q_at_boundary full/dir/busy/pulse: got %b expected 0110", {full[1], dir[1], busy[1], pulse[1]}); end
    wait_until(t1 + 2 * P - 1);
    n_cmp++; if (busy[1] !== 1'b1) begin n_bad++; $display("FAIL q_busy_end2: got %b expected 1", busy[1]); end
    wait_neg(1);
    n_cmp++; if (busy[1] !== 1'b0) begin n_bad++; $display("FAIL q_busy_fall: got %b expected 0", busy[1]); end
    wait_neg(2);
    n_cmp++; if (rises[1] - r1 !== 15) begin n_bad++; $display("FAIL q_count: got %0d expected 15", rises[1] - r1); end
    n_cmp++; if (setup_viol[1] - s1 !== 0) begin n_bad++; $display("FAIL q_dir_setup: got %0d violations expected 0", setup_viol[1] - s1); end
  endtask

  task automatic test_overwrite;
    int r0, r1, r2, n;
    r0 = rises[0]; r1 = rises[1]; r2 = rises[2];
    do_write(1, 1'b0, 3);
    do_write(0, 1'b1, 25);
    do_write(2, 1'b0, 7);
    do_write(1, 1'b1, 20);
    n_cmp++; if ({full[1], ovf[1]} !== 2'b10) begin n_bad++; $display("FAIL ow_first_buffer full/ovf: got %b expected 10", {full[1], ovf[1]}); end
    do_write(1, 1'b0, 8);
    n_cmp++; if ({full[1], ovf[1]} !== 2'b11) begin n_bad++; $display("FAIL ow_overwrite full/ovf: got %b expected 11", {full[1], ovf[1]}); end
    wait_neg(1);
    n_cmp++; if (ovf !== 3'b000) begin n_bad++; $display("FAIL ow_ovf_one_cycle: got %b expected 000", ovf); end
    do_write(3, 1'b1, 40);
    n_cmp++; if ({busy, full, ovf} !== 9'b111_010_000) begin n_bad++; $display("FAIL ow_ch3_ignored busy/full/ovf: got %b expected 111010000", {busy, full, ovf}); end
    n = 0;
    while (busy !== 3'b000 && n < 3 * P) begin @(negedge clk); n++; end
    n_cmp++; if (busy !== 3'b000) begin n_bad++; $display("FAIL ow_idle_timeout: got busy %b expected 000", busy); end
    wait_neg(2);
    n_cmp++; if (rises[0] - r0 !== 25) begin n_bad++; $display("FAIL ow_count_ch0: got %0d expected 25", rises[0] - r0); end
    n_cmp++; if (rises[1] - r1 !== 11) begin n_bad++; $display("FAIL ow_count_ch1: got %0d expected 11", rises[1] - r1); end
    n_cmp++; if (rises[2] - r2 !== 7) begin n_bad++; $display("FAIL ow_count_ch2: got %0d expected 7", rises[2] - r2); end
    n_cmp++; if (dir !== 3'b001) begin n_bad++; $display("FAIL ow_final_dir: got %b expected 001", dir); end
  endtask

  task automatic test_reset_mid;
    int n, r0;
    do_write(0, 1'b1, 50);
    do_write(0, 1'b0, 10);
    n_cmp++; if (full[0] !== 1'b1) begin n_bad++; $display("FAIL rm_full: got %b expected 1", full[0]); end
    n = 0;
    while (pulse[0] !== 1'b1 && n < 4 * H) begin @(negedge clk); n++; end
    n_cmp++; if (pulse[0] !== 1'b1) begin n_bad++; $display("FAIL rm_pulse_timeout: got %b expected 1", pulse[0]); end
    rst_n = 1'b0;
    wait_neg(1);
    n_cmp++; if ({pulse, busy, full, ovf, dir} !== 15'd0) begin n_bad++; $display("FAIL rm_outputs_cleared: got %b expected 0", {pulse, busy, full, ovf, dir}); end
    rst_n = 1'b1;
    r0 = rises[0];
    wait_neg(300);
    n_cmp++; if (busy !== 3'b000) begin n_bad++; $display("FAIL rm_busy_after_release: got %b expected 000", busy); end
    n_cmp++; if (rises[0] - r0 !== 0) begin n_bad++; $display("FAIL rm_no_pulses: got %0d expected 0", rises[0] - r0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full_clamp;
    test_queue;
    test_overwrite;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/step_dda_mc.md
# step_dda_mc

Multi-channel DDA step-pulse generator, the parametrised successor to the single-axis step generator in the motion CPLD. For each channel it accepts a per-period step command (magnitude plus direction) from the host write strobe and spreads exactly that many step pulses evenly over one fixed control period. It adds one command buffer per channel, so back-to-back commands run without gaps, and a direction setup guarantee. Its outputs drive the stepper-driver STEP/DIR pins directly.

## Interface
- NCH, 3: number of independent channels (1..8).
- NW, 7: magnitude width in bits.
- SLOTS, 50: pulse slots per control period.
- HALF_DIV, 200: clk cycles per half slot. The default gives a 20 us slot and a 1 ms period at 20 MHz.
- clk  in  1  system clock; everything is synchronous to its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- wr  in  1  host write strobe, level. A command is taken on its rising edge, detected against a registered copy.
- wr_ch  in  max(1,$clog2(NCH))  target channel, sampled on the edge cycle.
- wr_dir  in  1  direction for the command.
- wr_mag  in  NW  step count for the period.
- pulse  out  NCH  STEP output per channel.
- dir  out  NCH  DIR output per channel.
- busy  out  NCH  high while the channel is executing a period.
- full  out  NCH  channel buffer holds a pending command.
- ovf  out  NCH  one-cycle flag: a pending buffered command was overwritten.

## Operation
- **Reset (rst_n=0 at a clock edge).**
  - pulse, dir, busy, full and ovf go to 0.
  - Accumulators, counters and buffers are cleared.
  - The registered copy of wr is set to 1, so wr held high through reset release does not load a command.
- **Edge detect.** A write event occurs in cycle T when wr=1 and its registered copy is 0. If wr_ch ≥ NCH the event is ignored and no flag is raised.
- **Magnitude clamp.** The effective magnitude is min(wr_mag, SLOTS); it is clamped when the command is captured.
- **Per-channel states.**
  - IDLE → RUN on a write event: the command loads straight into the active registers.
  - RUN, buffer empty, write event: the command goes into the buffer and full=1.
  - RUN, buffer full, write event: the buffer is overwritten with the new command and ovf pulses high for 1 cycle.
  - End of period, buffer full: the buffered command becomes active (RUN continues) and full=0.
  - End of period, buffer empty: the channel returns to IDLE and busy=0.
  - A write in the same cycle as end of period is treated as arriving at a period boundary. If the buffer was full, active ← buffer and buffer ← new command. If it was empty, active ← new command. ovf is never raised in this case.
- **Load action.**
  - acc ← SLOTS/2 (integer division).
  - Slot counter and half counter ← 0.
  - dir output ← the command's direction.
- **DDA update at the start of each slot s (0..SLOTS−1).**
  - acc ← acc + mag.
  - If the result ≥ SLOTS: acc is reduced by SLOTS and the slot fires.
  - acc width is $clog2(2·SLOTS) bits; no overflow is possible.
  - Over one period exactly mag slots fire.
- **Pulse shape.** In a firing slot, pulse is low for the first HALF_DIV cycles and high for the second HALF_DIV cycles. pulse is therefore always low at slot and period boundaries.
- **mag=0.** The channel runs a full period with no pulses (a dwell) and busy stays high.
- **Channel independence.** Each channel has its own timebase, which starts at its own load.

## Timing
- Write edge in cycle T, channel IDLE:
  - busy=1 and dir valid from T+1.
  - Slot s spans cycles T+1+2·HALF_DIV·s through T+2·HALF_DIV·(s+1).
- Pulse timing:
  - Rises at slot start + HALF_DIV; high for exactly HALF_DIV cycles.
  - This gives ≥ HALF_DIV cycles of DIR-to-STEP setup.
- Period P = 2·HALF_DIV·SLOTS cycles.
  - No buffer: busy falls at T+1+P.
  - Buffer full: the next period starts at T+1+P with no gap and busy stays 1. dir changes in that cycle, while pulse is low.
- full and ovf change in the cycle after the write edge. ovf is high for exactly 1 cycle.
- Reset mid-period: all outputs are 0 on the cycle after the reset edge, including a pulse that was high.

## Test plan
1. **Reset with wr held.** Hold rst_n=0 for 4 cycles with wr=1, then release with wr still 1. Required: all outputs 0 and no command loaded.
2. **Basic period.** ch0, mag=25, dir=1 (defaults). Required:
   - exactly 25 pulses, each 200 cycles high, one in every other slot;
   - busy high for 20000 cycles;
   - dir=1 from T+1.
3. **Full and clamped magnitude.** Required:
   - mag=50: 50 pulses, one per slot, with a 200-cycle low gap between pulses;
   - mag=90: clamped to 50 pulses;
   - mag=0: no pulses, busy high for 20000 cycles.
4. **Queue.** ch1, mag=10 dir=0; during the run, mag=5 dir=1. Required:
   - full=1 until T+1+20000;
   - at that cycle dir switches to 1 and busy stays 1;
   - 5 pulses in the second period, each ≥ 200 cycles after the dir change;
   - busy falls at T+1+40000.
5. **Overwrite and independence.** Issue a third write to ch1 while full=1. Required:
   - ovf[1] pulses for 1 cycle and the latest command executes;
   - concurrent ch0/ch2 commands produce correct pulse counts unaffected;
   - wr_ch=3 is ignored.
6. **Reset mid-pulse.** Assert rst_n=0 while pulse[0]=1 and full[0]=1. Required: next cycle pulse, busy and full are 0, and no activity after release.
